// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Two-out-of-three vote used for mid-bit noise rejection.
  function automatic logic MAJ3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_sampler.sv
// Input synchroniser, per-bit sample counter and 3-sample majority vote.
module bit_sampler import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_rx,
  input  logic i_cnt_clr,    // hold the counter at 0 (receiver idle)
  output logic o_rx_s,       // synchronised line level
  output logic o_bit_strobe, // vote is valid this cycle (cnt = MID+1)
  output logic o_bit_end,    // last cycle of the bit (cnt wraps next)
  output logic o_bit_val     // majority-voted bit value
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] C_MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] C_MID    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] C_MID_P1 = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_rx_s;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain; resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
  end

  // Sample counter: 0..CLKS_PER_BIT-1 per bit, held at 0 while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             r_cnt <= '0;
    else if (i_cnt_clr)       r_cnt <= '0;
    else if (r_cnt == C_LAST) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

  // Capture the two early samples; the third is the live line at MID+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == C_MID_M1) r_s0 <= w_rx_s;
      if (r_cnt == C_MID)    r_s1 <= w_rx_s;
    end
  end

  assign o_rx_s       = w_rx_s;
  assign o_bit_strobe = (r_cnt == C_MID_P1);
  assign o_bit_end    = (r_cnt == C_LAST);
  assign o_bit_val    = MAJ3(r_s0, r_s1, w_rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM plus valid/ready output register.
module uart_rx_param import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  // Handshake: a word transfers in any cycle where valid_o && ready_i at the
  // rising clock edge; valid_o, data_o and the error flags are held stable
  // until that transfer, and a transfer plus a new load may share one cycle.

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE);

  rx_state_e            r_state;
  rx_state_e            w_next;
  logic                 w_rx_s;
  logic                 w_strobe;
  logic                 w_end;
  logic                 w_bit_val;
  logic                 w_cnt_clr;
  logic                 w_shift;
  logic                 w_pchk;
  logic                 w_stop_vote;
  logic                 w_done;
  logic                 w_par_bad;
  logic                 w_frm_final;
  logic                 r_armed;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_q;
  logic                 r_ferr_q;
  logic                 r_ovr;

  bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_rx        (rx_i),
    .i_cnt_clr   (w_cnt_clr),
    .o_rx_s      (w_rx_s),
    .o_bit_strobe(w_strobe),
    .o_bit_end   (w_end),
    .o_bit_val   (w_bit_val)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; the frame ends at the last stop bit's vote, not its wrap.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (r_armed && !w_rx_s) w_next = START;
      START: begin
        if (w_strobe && w_bit_val) w_next = IDLE;
        else if (w_end)            w_next = DATA;
      end
      DATA:   if (w_end && (r_idx == LAST_DATA)) w_next = (PMODE != NONE) ? PARITY : STOP;
      PARITY: if (w_end) w_next = STOP;
      STOP:   if (w_strobe && (r_idx == LAST_STOP)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath and output register.
  always_comb begin
    w_cnt_clr   = (r_state == IDLE);
    w_shift     = (r_state == DATA)   && w_strobe;
    w_pchk      = (r_state == PARITY) && w_strobe;
    w_stop_vote = (r_state == STOP)   && w_strobe;
    w_done      = w_stop_vote && (r_idx == LAST_STOP);
    w_par_bad   = r_par ^ w_bit_val ^ (PMODE == ODD);
    w_frm_final = r_frm_err | ~w_bit_val;
  end

  // Frame datapath: shift register, bit index, running parity and pending errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_rx_s) r_armed <= 1'b1;
        if (w_next == START) begin
          r_idx     <= '0;
          r_par     <= 1'b0;
          r_par_err <= 1'b0;
          r_frm_err <= 1'b0;
        end
      end
      if (w_shift) begin
        r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
        r_par   <= r_par ^ w_bit_val;
      end
      if (w_end) begin
        case (r_state)
          DATA:    r_idx <= (r_idx == LAST_DATA) ? '0 : r_idx + 1'b1;
          PARITY:  r_idx <= '0;
          STOP:    r_idx <= r_idx + 1'b1;
          default: r_idx <= r_idx;
        endcase
      end
      if (w_pchk && w_par_bad)         r_par_err <= 1'b1;
      if (w_stop_vote && !w_bit_val)   r_frm_err <= 1'b1;
      // A completed frame disarms until the line is seen high again (break guard).
      if (w_done)                      r_armed   <= 1'b0;
    end
  end

  // Output register: load on completion if free or being drained, else flag overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= 1'b0;
      r_ferr_q <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready_i) begin
          r_data   <= r_shift;
          r_perr_q <= r_par_err;
          r_ferr_q <= w_frm_final;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_perr_q;
  assign frame_err_o  = r_ferr_q;
  assign overrun_o    = r_ovr;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 8O1) at 16 clocks per bit.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct {
    int         lane;     // 0 = no parity, 1 = even, 2 = odd
    logic [7:0] d;
    bit         has_par;
    logic       pbit;
    logic       stop_val;
    int         spike;    // data bit index to spike at mid-bit, -1 for none
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] rx_bus;
  logic       ready;
  int         cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bz0, bz1, bz2;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_n (
    .clock(clock), .reset_n(reset_n), .rx_i(rx_bus[0]), .data_o(d0), .valid_o(v0), .ready_i(ready),
    .parity_err_o(pe0), .frame_err_o(fe0), .overrun_o(ov0), .busy_o(bz0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_e (
    .clock(clock), .reset_n(reset_n), .rx_i(rx_bus[1]), .data_o(d1), .valid_o(v1), .ready_i(ready),
    .parity_err_o(pe1), .frame_err_o(fe1), .overrun_o(ov1), .busy_o(bz1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_o (
    .clock(clock), .reset_n(reset_n), .rx_i(rx_bus[2]), .data_o(d2), .valid_o(v2), .ready_i(ready),
    .parity_err_o(pe2), .frame_err_o(fe2), .overrun_o(ov2), .busy_o(bz2));

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];
  int acc0 = 0, acc1 = 0, acc2 = 0;
  int hi0 = 0, ov0_cnt = 0, ov_other = 0;
  int rise0 = 0;
  logic prev_v0 = 1'b0;
  int bit_start_cyc = 0;
  int frame_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor samples 3 ns after the input-driving negedge, i.e. what the next posedge sees.
  always @(negedge clock) begin
    #3;
    if (v0 && !prev_v0) rise0 = cyc;
    prev_v0 = v0;
    if (v0) hi0++;
    if (ov0) ov0_cnt++;
    if (ov1 || ov2) ov_other++;
    if (v0 && ready) begin
      acc0++;
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane0 unexpected word: got %0h expected none", {pe0, fe0, d0});
      end else check("lane0 word {perr,ferr,data}", {22'd0, pe0, fe0, d0}, {22'd0, exp_q0.pop_front()});
    end
    if (v1 && ready) begin
      acc1++;
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane1 unexpected word: got %0h expected none", {pe1, fe1, d1});
      end else check("lane1 word {perr,ferr,data}", {22'd0, pe1, fe1, d1}, {22'd0, exp_q1.pop_front()});
    end
    if (v2 && ready) begin
      acc2++;
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane2 unexpected word: got %0h expected none", {pe2, fe2, d2});
      end else check("lane2 word {perr,ferr,data}", {22'd0, pe2, fe2, d2}, {22'd0, exp_q2.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input int lane, input logic val, input bit spike);
    for (int c = 0; c < CPB; c++) begin
      @(negedge clock);
      if (c == 0) bit_start_cyc = cyc;
      rx_bus[lane] = (spike && c == CPB / 2) ? ~val : val;
    end
  endtask

  task automatic send_frame(input int lane, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop_val, input int spike);
    send_bit(lane, 1'b0, 1'b0);
    frame_start_cyc = bit_start_cyc;
    for (int i = 0; i < 8; i++) send_bit(lane, d[i], spike == i);
    if (has_par) send_bit(lane, pbit, 1'b0);
    send_bit(lane, stop_val, 1'b0);
    send_bit(lane, 1'b1, 1'b0);
  endtask

  task automatic push_exp(input int lane, input logic [9:0] w);
    if (lane == 0)      exp_q0.push_back(w);
    else if (lane == 1) exp_q1.push_back(w);
    else                exp_q2.push_back(w);
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];
  int   snap_a, snap_b;

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Hand-computed frames: parity column is the bit actually sent on the wire.
    vecs[0] = '{1, 8'h03, 1'b1, 1'b1, 1'b1, -1, 8'h03, 1'b1, 1'b0}; // even, xor=1 -> error
    vecs[1] = '{1, 8'h03, 1'b1, 1'b0, 1'b1, -1, 8'h03, 1'b0, 1'b0}; // even, xor=0 -> ok
    vecs[2] = '{2, 8'h03, 1'b1, 1'b1, 1'b1, -1, 8'h03, 1'b0, 1'b0}; // odd,  xor=1 -> ok
    vecs[3] = '{2, 8'h03, 1'b1, 1'b0, 1'b1, -1, 8'h03, 1'b1, 1'b0}; // odd,  xor=0 -> error
    vecs[4] = '{1, 8'h80, 1'b1, 1'b1, 1'b1, -1, 8'h80, 1'b0, 1'b0}; // even, one 1 + pbit 1
    vecs[5] = '{2, 8'hFF, 1'b1, 1'b1, 1'b1, -1, 8'hFF, 1'b0, 1'b0}; // odd, eight 1s + pbit 1
    vecs[6] = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, -1, 8'h5A, 1'b0, 1'b1}; // stop bit 0 -> frame error
    vecs[7] = '{0, 8'h11, 1'b0, 1'b0, 1'b1, -1, 8'h11, 1'b0, 1'b0}; // clean frame clears it
    vecs[8] = '{0, 8'h08, 1'b0, 1'b0, 1'b1,  3, 8'h08, 1'b0, 1'b0}; // spike on bit 3 is voted out

    reset_n = 1'b0;
    rx_bus  = 3'b111;
    ready   = 1'b1;
    repeat (5) @(negedge clock);
    #3;
    check("reset outputs lane0", {18'd0, d0, v0, pe0, fe0, ov0, bz0}, 32'd0);
    check("reset outputs lane1", {18'd0, d1, v1, pe1, fe1, ov1, bz1}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) send_bit(0, 1'b1, 1'b0);

    // 8N1 0xA5: vote lands 154 cycles after rx_s falls, valid one cycle later;
    // rx_s falls two posedges after the start bit is driven, so 2 + 155 = 157.
    push_exp(0, {1'b0, 1'b0, 8'hA5});
    snap_a = hi0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    check("A5 valid latency", rise0 - frame_start_cyc, 157);
    check("A5 valid width", hi0 - snap_a, 1);

    for (int i = 0; i < 9; i++) begin
      push_exp(vecs[i].lane, {vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_d});
      send_frame(vecs[i].lane, vecs[i].d, vecs[i].has_par, vecs[i].pbit, vecs[i].stop_val, vecs[i].spike);
    end

    // Overrun: consumer stalled across two frames; the second must be dropped.
    @(negedge clock);
    ready = 1'b0;
    snap_a = ov0_cnt;
    snap_b = acc0;
    push_exp(0, {1'b0, 1'b0, 8'h12});
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, -1);
    #3;
    check("overrun pulse count", ov0_cnt - snap_a, 1);
    check("overrun held data", {24'd0, d0}, 32'h12);
    check("overrun held valid", {31'd0, v0}, 1);
    @(negedge clock);
    ready = 1'b1;
    @(negedge clock);
    #4;
    check("overrun accepted once", acc0 - snap_b, 1);
    check("valid low after accept", {31'd0, v0}, 0);

    // Start glitch: 3 low cycles look like a start but vote back to 1.
    snap_b = acc0;
    @(negedge clock);
    rx_bus[0] = 1'b0;
    repeat (3) @(negedge clock);
    rx_bus[0] = 1'b1;
    repeat (3) @(negedge clock);
    #3;
    check("glitch busy", {31'd0, bz0}, 1);
    repeat (30) @(negedge clock);
    #3;
    check("glitch back to idle", {31'd0, bz0}, 0);
    check("glitch no word", acc0 - snap_b, 0);
    check("glitch valid", {31'd0, v0}, 0);

    // Reset during data bit 4 abandons the frame.
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1'b0);
    repeat (8) @(negedge clock);
    #3;
    check("busy mid frame", {31'd0, bz0}, 1);
    @(negedge clock);
    reset_n   = 1'b0;
    rx_bus[0] = 1'b1;
    #3;
    check("mid-frame reset lane0", {18'd0, d0, v0, pe0, fe0, ov0, bz0}, 32'd0);
    check("mid-frame reset lane1 data", {24'd0, d1}, 32'd0);
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) send_bit(0, 1'b1, 1'b0);
    snap_b = acc0;
    push_exp(0, {1'b0, 1'b0, 8'hC3});
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
    check("post-reset words", acc0 - snap_b, 1);
    check("post-reset data", {24'd0, d0}, 32'hC3);

    check("lane0 leftovers", exp_q0.size(), 0);
    check("lane1 leftovers", exp_q1.size(), 0);
    check("lane2 leftovers", exp_q2.size(), 0);
    check("parity lanes overrun", ov_other, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
